// File: rtl/dnn_fc_layer_pkg.sv
// Shared types and FP16 helpers for the fully connected layer.
// Pure declarations: no state, no timing.
package dnn_pkg96;

  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    ACT_NONE     = 2'b00,
    ACT_RELU     = 2'b01,
    ACT_LEAKY    = 2'b10,
    ACT_NONE_ALT = 2'b11
  } act_mode_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACT, OUT} state_t;

  function automatic logic [4:0] fp16_exp(input logic [15:0] v);
    return v[14:10];
  endfunction

  function automatic logic fp16_is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'h0);
  endfunction

endpackage

// File: rtl/dnn_fc_layer_act.sv
// One-lane FP16 activation (none / ReLU / leaky ReLU with slope 1/8), bit-level only.
// Combinational, no handshake.
module fp16_activation
  import dnn_pkg96::*;
(
  input  logic [1:0]  act_mode,
  input  logic [15:0] value,
  output logic [15:0] result
);

  always_comb begin
    result = value;
    case (act_mode_t'(act_mode))
      ACT_RELU: begin
        if (value[15]) result = FP16_ZERO;
      end
      ACT_LEAKY: begin
        // Scaling by 1/8 is an exponent decrement; too-small values flush to signed zero.
        if (value[15] && fp16_exp(value) != 5'h1F) begin
          if (fp16_exp(value) <= 5'd3) result = {value[15], 15'h0};
          else result = {value[15], fp16_exp(value) - 5'd3, value[9:0]};
        end
      end
      default: result = value;
    endcase
  end

endmodule

// File: rtl/floating_point_0.sv
// FP16 fused multiply-add core (a*b+c, round to nearest even), fixed LATENCY pipeline.
// Non-blocking: results are produced LATENCY cycles after all three tvalids, no backpressure.
module floating_point_0 #(
  parameter int LATENCY = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_a_tvalid,
  input  logic [15:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [15:0] s_axis_b_tdata,
  input  logic        s_axis_c_tvalid,
  input  logic [15:0] s_axis_c_tdata,
  output logic        m_axis_result_tvalid,
  output logic [15:0] m_axis_result_tdata
);

  function automatic logic [47:0] shr_sticky(input logic [47:0] v, input int d);
    if (d <= 0) return v;
    if (d >= 48) return {47'b0, |v};
    return (v >> d) | {47'b0, |(v & ((48'd1 << d) - 48'd1))};
  endfunction

  function automatic logic [15:0] fma16(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
    logic [10:0] ma, mb, mc, m;
    logic [21:0] mp;
    logic [47:0] xp, xc, s;
    logic [11:0] mr;
    logic        sp, rs, guard, rest;
    logic        a_inf, b_inf, c_inf, a_zero, b_zero, any_nan;
    int          ea, eb, ec, ep, emax, p, ef, r;
    sp     = a[15] ^ b[15];
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
    c_inf  = (c[14:10] == 5'h1F) && (c[9:0] == 10'h0);
    a_zero = (a[14:0] == 15'h0);
    b_zero = (b[14:0] == 15'h0);
    any_nan = ((a[14:10] == 5'h1F) && (a[9:0] != 10'h0)) ||
              ((b[14:10] == 5'h1F) && (b[9:0] != 10'h0)) ||
              ((c[14:10] == 5'h1F) && (c[9:0] != 10'h0));
    if (any_nan || (a_inf && b_zero) || (b_inf && a_zero) ||
        ((a_inf || b_inf) && c_inf && (sp != c[15]))) return 16'h7E00;
    if (a_inf || b_inf) return {sp, 15'h7C00};
    if (c_inf) return c;

    ma = {a[14:10] != 5'h0, a[9:0]};
    mb = {b[14:10] != 5'h0, b[9:0]};
    mc = {c[14:10] != 5'h0, c[9:0]};
    ea = (a[14:10] == 5'h0) ? 1 : int'(a[14:10]);
    eb = (b[14:10] == 5'h0) ? 1 : int'(b[14:10]);
    ec = (c[14:10] == 5'h0) ? 1 : int'(c[14:10]);
    mp = {11'b0, ma} * {11'b0, mb};
    if (mp == 22'h0 && mc == 11'h0) return {sp & c[15], 15'h0};
    ep = (mp == 22'h0) ? -100 : ea + eb - 15;
    if (mc == 11'h0) ec = -100;

    // Both terms share the scale value = x * 2^(E-59) inside a 48-bit frame.
    xp   = {2'b0, mp, 24'b0};
    xc   = {3'b0, mc, 34'b0};
    emax = (ep > ec) ? ep : ec;
    xp   = shr_sticky(xp, emax - ep);
    xc   = shr_sticky(xc, emax - ec);
    if (sp == c[15]) begin
      s = xp + xc; rs = sp;
    end else if (xp >= xc) begin
      s = xp - xc; rs = sp;
    end else begin
      s = xc - xp; rs = c[15];
    end
    if (s == 48'h0) return 16'h0000;

    p = 0;
    for (int i = 0; i < 48; i++) if (s[i]) p = i;
    ef = p + emax - 44;
    if (ef < 1) ef = 1;
    r = ef + 34 - emax;
    if (r <= 0) begin
      m = 11'(s << (-r)); guard = 1'b0; rest = 1'b0;
    end else if (r > 48) begin
      m = 11'h0; guard = 1'b0; rest = |s;
    end else begin
      m     = 11'(s >> r);
      guard = |((s >> (r - 1)) & 48'd1);
      rest  = |(s & ((48'd1 << (r - 1)) - 48'd1));
    end
    mr = {1'b0, m} + {11'b0, guard & (rest | m[0])};
    if (mr[11]) begin
      mr = mr >> 1;
      ef = ef + 1;
    end
    if (ef >= 31) return {rs, 15'h7C00};
    return {rs, mr[10] ? 5'(ef) : 5'h0, mr[9:0]};
  endfunction

  logic [LATENCY-1:0]       vld_pipe;
  logic [LATENCY-1:0][15:0] dat_pipe;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= s_axis_a_tvalid & s_axis_b_tvalid & s_axis_c_tvalid;
      dat_pipe[0] <= fma16(s_axis_a_tdata, s_axis_b_tdata, s_axis_c_tdata);
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign m_axis_result_tvalid = vld_pipe[LATENCY-1];
  assign m_axis_result_tdata  = dat_pipe[LATENCY-1];

endmodule

// File: rtl/dnn_fc_layer.sv
// FP16 fully connected layer: bias + N_IN96 inputs into N_OUT96 neurons, one FMA per neuron.
// Result after 1+(N_IN96+1)(L+2)+1 cycles; one vector in flight, held in OUT until out_ready96.
module dnn_fc_layer
  import dnn_pkg96::*;
#(
  parameter int N_IN96        = 6,
  parameter int N_OUT96       = 4,
  parameter logic [(N_IN96+1)*N_OUT96*16-1:0] WEIGHTS96 = '0,
  parameter int FMA_LATENCY96 = 4
) (
  input  logic                   clk96,
  input  logic                   rst_n96,
  input  logic                   in_valid96,
  output logic                   in_ready96,
  input  logic [N_IN96*16-1:0]   in_data96,
  input  logic [1:0]             act_mode96,
  output logic                   out_valid96,
  input  logic                   out_ready96,
  output logic [N_OUT96*16-1:0]  out_data96,
  output logic                   out_nan96,
  output logic                   busy96
);

  localparam int KW = $clog2(N_IN96 + 1);
  // Row 0 holds the bias, applied against the constant x[0] = 1.0.
  localparam logic [N_IN96:0][N_OUT96-1:0][15:0] W = WEIGHTS96;

  state_t                     state;
  logic [KW-1:0]              k;
  logic [N_IN96:0][15:0]      x;
  logic [1:0]                 mode;
  logic [N_OUT96-1:0][15:0]   acc;
  logic [N_OUT96-1:0]         done;
  logic                       core_vld;
  logic [15:0]                core_a;
  logic [N_OUT96-1:0][15:0]   core_b, core_c;
  logic [N_OUT96-1:0]         res_vld, lane_nan, done_nxt;
  logic [N_OUT96-1:0][15:0]   res_dat, act_dat;

  assign done_nxt = done | res_vld;

  for (genvar j = 0; j < N_OUT96; j++) begin : g_lane
    floating_point_0 #(.LATENCY(FMA_LATENCY96)) u_fma (
      .aclk                 (clk96),
      .aresetn              (rst_n96),
      .s_axis_a_tvalid      (core_vld),
      .s_axis_a_tdata       (core_a),
      .s_axis_b_tvalid      (core_vld),
      .s_axis_b_tdata       (core_b[j]),
      .s_axis_c_tvalid      (core_vld),
      .s_axis_c_tdata       (core_c[j]),
      .m_axis_result_tvalid (res_vld[j]),
      .m_axis_result_tdata  (res_dat[j])
    );

    fp16_activation u_act (
      .act_mode (mode),
      .value    (acc[j]),
      .result   (act_dat[j])
    );

    assign lane_nan[j] = fp16_is_nan(acc[j]);
  end

  always_ff @(posedge clk96 or negedge rst_n96) begin
    if (!rst_n96) begin
      state       <= IDLE;
      k           <= '0;
      x           <= '0;
      mode        <= '0;
      acc         <= '0;
      done        <= '0;
      core_vld    <= 1'b0;
      core_a      <= '0;
      core_b      <= '0;
      core_c      <= '0;
      in_ready96  <= 1'b1;
      out_valid96 <= 1'b0;
      out_data96  <= '0;
      out_nan96   <= 1'b0;
      busy96      <= 1'b0;
    end else begin
      core_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid96 && in_ready96) begin
            x[0] <= FP16_ONE;
            for (int i = 0; i < N_IN96; i++) x[i+1] <= in_data96[i*16 +: 16];
            mode       <= act_mode96;
            acc        <= '0;
            done       <= '0;
            k          <= '0;
            in_ready96 <= 1'b0;
            busy96     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          core_vld <= 1'b1;
          core_a   <= x[k];
          for (int j = 0; j < N_OUT96; j++) core_b[j] <= W[k][j];
          core_c   <= acc;
          state    <= WAIT;
        end
        WAIT: begin
          for (int j = 0; j < N_OUT96; j++) if (res_vld[j]) acc[j] <= res_dat[j];
          done <= done_nxt;
          if (&done_nxt) begin
            done <= '0;
            if (k == KW'(N_IN96)) begin
              state <= ACT;
            end else begin
              k     <= k + 1'b1;
              state <= ISSUE;
            end
          end
        end
        ACT: begin
          out_data96  <= act_dat;
          out_nan96   <= |lane_nan;
          out_valid96 <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (out_ready96) begin
            out_valid96 <= 1'b0;
            in_ready96  <= 1'b1;
            busy96      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_fc_layer.sv
// Bench for dnn_fc_layer: 2 inputs x 2 neurons, directed plan cases plus randomized vectors
// scored against a real-arithmetic reference of the layer.
module tb_dnn_fc_layer;

  localparam int N_IN  = 2;
  localparam int N_OUT = 2;
  localparam int LAT   = 4;
  localparam logic [15:0] WT [3][2] = '{'{16'h0000, 16'hBC00},
                                       '{16'h3C00, 16'h4000},
                                       '{16'h4000, 16'h3C00}};
  localparam logic [95:0] WTS = {16'h3C00, 16'h4000, 16'h4000, 16'h3C00, 16'hBC00, 16'h0000};

  logic        clk96 = 1'b0;
  logic        rst_n96 = 1'b0;
  logic        in_valid96 = 1'b0;
  logic        out_ready96 = 1'b0;
  logic [31:0] in_data96 = '0;
  logic [1:0]  act_mode96 = '0;
  logic        in_ready96, out_valid96, out_nan96, busy96;
  logic [31:0] out_data96;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk96 = ~clk96;

  dnn_fc_layer #(
    .N_IN96(N_IN), .N_OUT96(N_OUT), .WEIGHTS96(WTS), .FMA_LATENCY96(LAT)
  ) dut (
    .clk96(clk96), .rst_n96(rst_n96),
    .in_valid96(in_valid96), .in_ready96(in_ready96), .in_data96(in_data96),
    .act_mode96(act_mode96),
    .out_valid96(out_valid96), .out_ready96(out_ready96), .out_data96(out_data96),
    .out_nan96(out_nan96), .busy96(busy96)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real fp16_to_real(input logic [15:0] h);
    real sgn, man;
    int  e;
    sgn = h[15] ? -1.0 : 1.0;
    man = real'(int'(h[9:0]));
    e   = int'(h[14:10]);
    if (e == 0) return sgn * man * (2.0 ** -24.0);
    return sgn * (1.0 + man / 1024.0) * (2.0 ** real'(e - 15));
  endfunction

  function automatic logic [15:0] real_to_fp16(input real r);
    real  a;
    int   e;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    return {s, 5'(e + 15), 10'(int'((a - 1.0) * 1024.0))};
  endfunction

  function automatic logic is_nan16(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'h0);
  endfunction

  // Neuron j output: activation of (bias + sum x_i * w_ij).
  function automatic logic [15:0] model_lane(input logic [15:0] x1, input logic [15:0] x2,
                                             input logic [1:0] mode, input int j);
    real xs[3];
    real acc;
    xs[0] = 1.0;
    xs[1] = fp16_to_real(x1);
    xs[2] = fp16_to_real(x2);
    acc = 0.0;
    for (int i = 0; i < 3; i++) acc = acc + xs[i] * fp16_to_real(WT[i][j]);
    case (mode)
      2'b01: return (acc < 0.0) ? 16'h0000 : real_to_fp16(acc);
      2'b10: begin
        if (acc >= 0.0) return real_to_fp16(acc);
        if (-acc < 2.0 ** -11.0) return 16'h8000;
        return real_to_fp16(acc * 0.125);
      end
      default: return real_to_fp16(acc);
    endcase
  endfunction

  function automatic logic [15:0] rand_x();
    int v;
    v = int'($urandom_range(0, 32)) - 16;
    return real_to_fp16(real'(v) / 2.0);
  endfunction

  task automatic run_inf(input logic [15:0] x1, input logic [15:0] x2, input logic [1:0] mode,
                         input int hold, input bit tied, output int lat);
    int          n;
    logic [31:0] held, exp_dat;
    n = 0;
    while (!in_ready96 && n < 100) begin @(posedge clk96); #1; n++; end
    chk("in_ready_before_start", 32'(in_ready96), 32'd1);
    in_data96   = {x2, x1};
    act_mode96  = mode;
    in_valid96  = 1'b1;
    out_ready96 = tied;
    @(posedge clk96); #1;
    in_valid96 = 1'b0;
    n = 1;
    while (!out_valid96 && n < 200) begin @(posedge clk96); #1; n++; end
    lat = n;
    chk("out_valid_timeout", 32'(out_valid96), 32'd1);
    if (is_nan16(x1) || is_nan16(x2)) begin
      chk("nan_flag", 32'(out_nan96), 32'd1);
      chk("nan_lane0", {30'b0, out_data96[15], is_nan16(out_data96[15:0])}, 32'd1);
      chk("nan_lane1", {30'b0, out_data96[31], is_nan16(out_data96[31:16])}, 32'd1);
    end else begin
      exp_dat = {model_lane(x1, x2, mode, 1), model_lane(x1, x2, mode, 0)};
      chk("out_data", out_data96, exp_dat);
      chk("out_nan", 32'(out_nan96), 32'd0);
    end
    held = out_data96;
    if (!tied) begin
      for (int h = 0; h < hold; h++) begin
        in_valid96 = 1'($urandom_range(0, 1));
        @(posedge clk96); #1;
        chk("hold_data", out_data96, held);
        chk("hold_out_valid", 32'(out_valid96), 32'd1);
        chk("hold_in_ready", 32'(in_ready96), 32'd0);
      end
    end
    in_valid96  = 1'b0;
    out_ready96 = 1'b1;
    @(posedge clk96); #1;
    out_ready96 = tied;
    chk("accept_in_ready", 32'(in_ready96), 32'd1);
    chk("accept_out_valid", 32'(out_valid96), 32'd0);
    if (!tied) begin
      @(posedge clk96); #1;
      chk("no_queued_input", 32'(busy96), 32'd0);
    end
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk96);
    #1;
    chk("rst_in_ready", 32'(in_ready96), 32'd1);
    chk("rst_out_valid", 32'(out_valid96), 32'd0);
    chk("rst_out_data", out_data96, 32'd0);
    chk("rst_out_nan", 32'(out_nan96), 32'd0);
    chk("rst_busy", 32'(busy96), 32'd0);
    rst_n96 = 1'b1;
    @(posedge clk96); #1;

    run_inf(16'h3C00, 16'h4000, 2'b01, 0, 1'b0, lat);
    chk("plan_relu_pos", out_data96, {16'h4200, 16'h4500});
    chk("latency", 32'(lat), 32'(1 + (N_IN + 1) * (LAT + 2) + 1));

    run_inf(16'hBC00, 16'h0000, 2'b00, 0, 1'b0, lat);
    chk("plan_none", out_data96, {16'hC200, 16'hBC00});
    run_inf(16'hBC00, 16'h0000, 2'b01, 0, 1'b0, lat);
    chk("plan_relu_neg", out_data96, {16'h0000, 16'h0000});
    run_inf(16'hBC00, 16'h0000, 2'b10, 0, 1'b0, lat);
    chk("plan_leaky", out_data96, {16'hB600, 16'hB000});

    run_inf(16'h3C00, 16'h4000, 2'b01, 10, 1'b0, lat);
    run_inf(16'h7E00, 16'h0000, 2'b01, 0, 1'b0, lat);

    // Abort in the middle of the k=1 wait and make sure nothing carries over.
    in_data96  = {16'h4000, 16'hBC00};
    act_mode96 = 2'b00;
    in_valid96 = 1'b1;
    @(posedge clk96); #1;
    in_valid96 = 1'b0;
    repeat (10) @(posedge clk96);
    #1;
    chk("busy_before_abort", 32'(busy96), 32'd1);
    rst_n96 = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid96), 32'd0);
    chk("abort_in_ready", 32'(in_ready96), 32'd1);
    chk("abort_busy", 32'(busy96), 32'd0);
    @(posedge clk96); #1;
    rst_n96 = 1'b1;
    run_inf(16'h3C00, 16'h4000, 2'b01, 0, 1'b0, lat);
    chk("after_abort", out_data96, {16'h4200, 16'h4500});

    run_inf(16'hBC00, 16'h0000, 2'b00, 0, 1'b1, lat);
    run_inf(16'h3C00, 16'h4000, 2'b00, 0, 1'b1, lat);
    chk("b2b_second", out_data96, {16'h4200, 16'h4500});

    for (int t = 0; t < 24; t++) begin
      run_inf(rand_x(), rand_x(), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
